// File: rtl/mem_responder.sv
// mem_responder: slave end of a valid/ready memory request interface.
// Accepts one request at a time, waits a configurable number of cycles,
// commits the access to word-addressed storage, and holds the response
// until the initiator takes it.
// Optional build macro MEM_RESP_RAND_LAT_EN replaces the fixed LATENCY with a
// pseudo-random 0..7 wait drawn from a free-running 8-bit LFSR.
module mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
    parameter int                    LATENCY    = 1,
    parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wen,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int                    IDX_W = $clog2(DEPTH);
    localparam int                    CNT_W = (LATENCY > 7) ? $clog2(LATENCY + 1) : 3;
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wmask_q, wmask_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [31:0]             mem [DEPTH];

    logic                    accept_s;
    logic [CNT_W-1:0]        load_s;
    logic                    commit_s;
    logic [ADDR_WIDTH-1:0]   cm_addr_s;
    logic                    cm_wen_s;
    logic [31:0]             cm_wdata_s;
    logic [3:0]              cm_wmask_s;
    logic [ADDR_WIDTH-1:0]   off_s;
    logic                    in_range_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    unused_s;

    assign accept_s   = req_valid & req_ready_q;
    // Unsigned offset: addresses below BASE wrap to a huge offset and fail the range test.
    assign off_s      = cm_addr_s - BASE;
    assign in_range_s = (off_s < SPAN);
    assign idx_s      = off_s[IDX_W+1:2];

`ifdef MEM_RESP_RAND_LAT_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Next LFSR value: Fibonacci form, taps 8,6,5,4.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, advances every cycle regardless of traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign load_s   = CNT_W'(lfsr_q[2:0]);
    assign unused_s = ^off_s[1:0];
`else
    assign load_s   = CNT_W'(LATENCY);
    assign unused_s = ^{off_s[1:0], LFSR_SEED};
`endif

    // Next-state, request capture, and commit/response computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit_s    = 1'b0;
        cm_addr_s   = addr_q;
        cm_wen_s    = wen_q;
        cm_wdata_s  = wdata_q;
        cm_wmask_s  = wmask_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = load_s;
                    if (load_s != {CNT_W{1'b0}}) begin
                        state_d = S_WAIT;
                    end else begin
                        // Zero wait: commit straight from the live request fields.
                        state_d    = S_RESP;
                        commit_s   = 1'b1;
                        cm_addr_s  = req_addr;
                        cm_wen_s   = req_wen;
                        cm_wdata_s = req_wdata;
                        cm_wmask_s = req_wmask;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit_s) begin
            rsp_err_d   = ~in_range_s;
            rsp_rdata_d = (!cm_wen_s && in_range_s) ? mem[idx_s] : 32'h0000_0000;
        end else begin
            rsp_err_d   = rsp_err_d;
        end

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // Control and response registers; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wen_q       <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            wmask_q     <= 4'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-masked write commit; reset cycle suppresses a commit that would land on it.
    always_ff @(posedge clk) begin
        if (rst && commit_s && cm_wen_s && in_range_s) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_wmask_s[b]) begin
                    mem[idx_s][8*b +: 8] <= cm_wdata_s[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard of expected responses
// and a small reference model of the backing storage.
module tb_mem_responder;

    localparam int          LAT   = 1;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wmask = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .BASE       (BASE),
        .LATENCY    (LAT),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model_mem [int];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: predicts the response and updates storage for writes.
    function automatic exp_t predict(input logic [31:0] a, input logic w,
                                     input logic [31:0] wd, input logic [3:0] m);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] cur;
        int          idx;
        off     = a - BASE;
        idx     = int'(off >> 2);
        e.err   = (off >= 32'(DEPTH * 4));
        e.rdata = 32'h0;
        if (!e.err) begin
            cur = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) cur[8*b +: 8] = wd[8*b +: 8];
                end
                model_mem[idx] = cur;
            end else begin
                e.rdata = cur;
            end
        end
        return e;
    endfunction

    // Present a request at a negedge, wait for acceptance, then scramble req_*.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] m, input bit push);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_wen   = w;
        req_wdata = wd;
        req_wmask = m;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        if (push) sb.push_back(predict(a, w, wd, m));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFF0;
        req_wen   = ~w;
        req_wdata = 32'h0BAD_F00D;
        req_wmask = 4'hF;
    endtask

    // Wait for the response, check latency, optional stall, data and handshake.
    task automatic collect(input int hold);
        int   lat = 1;
        exp_t e;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
`ifdef MEM_RESP_RAND_LAT_EN
        check("latency_in_1_to_8", {31'b0, (lat >= 1 && lat <= 8)}, 32'd1);
`else
        check("latency", lat, LAT + 1);
`endif
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed response with no expected entry");
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < hold; k++) begin
                check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
                check("hold_rsp_rdata", rsp_rdata, e.rdata);
                check("hold_req_ready_low", {31'b0, req_ready}, 32'd0);
                @(negedge clk);
            end
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] m, input int hold);
        issue(a, w, wd, m, 1'b1);
        collect(hold);
    endtask

    // Global guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] addrs [4];
        int          n_rand;
        addrs[0] = 32'h8000_0000;
        addrs[1] = 32'h8000_0010;
        addrs[2] = 32'h8000_3FFC;
        addrs[3] = 32'h8000_4000;
`ifdef MEM_RESP_RAND_LAT_EN
        n_rand = 100;
`else
        n_rand = 16;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);

        // Basic write then read of word 0
        txn(32'h8000_0000, 1'b1, 32'h0000_0013, 4'hF, 0);
        txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0);

        // Byte-masked write over zero
        txn(32'h8000_0010, 1'b1, 32'h0000_0000, 4'hF, 0);
        txn(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0101, 0);
        txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 5);

        // Empty-mask write leaves storage unchanged
        txn(32'h8000_0010, 1'b1, 32'hAAAA_AAAA, 4'h0, 0);
        txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0);

        // Range boundaries
        txn(32'h8000_3FFC, 1'b1, 32'h1234_5678, 4'hF, 0);
        txn(32'h8000_3FFC, 1'b0, 32'h0, 4'h0, 0);
        txn(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0);
        txn(32'h8000_4000, 1'b0, 32'h0, 4'h0, 0);
        txn(32'h8000_4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0);
        txn(32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, 0);
        txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0);
        txn(32'h8000_3FFC, 1'b0, 32'h0, 4'h0, 0);

`ifndef MEM_RESP_RAND_LAT_EN
        // Reset while the write is still waiting: nothing committed
        issue(32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        check("wait_rsp_valid_low", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("wait_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("wait_rst_req_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0);
`endif

        // Reset while the response is pending: committed write survives
        issue(32'h8000_0020, 1'b1, 32'h5555_5555, 4'hF, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resp_before_rst", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("resp_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("resp_rst_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        model_mem[8] = 32'h5555_5555;
        txn(32'h8000_0020, 1'b0, 32'h0, 4'h0, 0);

        // Back-to-back reads over known words and an out-of-range address
        for (int i = 0; i < n_rand; i++) begin
            txn(addrs[$urandom_range(0, 3)], 1'b0, 32'h0, 4'h0, 0);
        end

        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
